// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the 6502 stack sequencer.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    OP_PUSH1 = 3'd0,
    OP_PULL1 = 3'd1,
    OP_PUSH2 = 3'd2,
    OP_PULL2 = 3'd3,
    OP_PUSH3 = 3'd4,
    OP_PULL3 = 3'd5,
    OP_LOAD  = 3'd6,
    OP_STORE = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PUSH,
    ST_PULL_PRE,
    ST_PULL,
    ST_XFER
  } state_e;

  localparam logic [1:0] SEL_SINGLE = 2'd0;
  localparam logic [1:0] SEL_PCH    = 2'd1;
  localparam logic [1:0] SEL_PCL    = 2'd2;
  localparam logic [1:0] SEL_P      = 2'd3;

  localparam logic [7:0] SP_PAGE = 8'h01;

  // Number of memory bytes moved by an op; LOAD/STORE count as one transfer.
  function automatic logic [1:0] op_bytes(input op_e op);
    case (op)
      OP_PUSH2, OP_PULL2: op_bytes = 2'd2;
      OP_PUSH3, OP_PULL3: op_bytes = 2'd3;
      default:            op_bytes = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/stack_seq_byteorder.sv
// Maps (op, byte index) to the byte source/destination select.
module stack_seq_byteorder
  import stack_seq_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [1:0] i_idx,
  output logic [1:0] o_sel
);

  // Pushes go high byte first (PCH, PCL, P); pulls unwind in reverse.
  always_comb begin
    o_sel = SEL_SINGLE;
    case (op_e'(i_op))
      OP_PUSH2, OP_PUSH3: o_sel = i_idx + 2'd1;
      OP_PULL2:           o_sel = 2'd2 - i_idx;
      OP_PULL3:           o_sel = 2'd3 - i_idx;
      default:            o_sel = SEL_SINGLE;
    endcase
  end

endmodule

// File: rtl/stack_sequencer.sv
// Stack pointer / page-1 access sequencer for the 6502 core.
// Define STACK_SEQ_WRAP_CHK_EN to enable the sticky stack wrap error (stk_err).
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter logic [7:0] SP_INIT = 8'hFA
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] sb_in,
  output logic       busy,
  output logic       done,
  output logic       sp_clr,
  output logic       sp_wa,
  output logic       sp_dec,
  output logic       sp_inc,
  output logic       sp_sboa,
  output logic       sp_adloa,
  output logic       adh_page1,
  output logic       mem_we,
  output logic       mem_re,
  output logic [1:0] byte_sel,
  output logic       stk_err
);

  state_e     r_state, w_next;
  op_e        r_op;
  logic [1:0] r_cnt, r_idx;
  logic [7:0] r_shadow;
  logic       r_rdy;
  logic       w_last;
  logic [1:0] w_sel;

  assign w_last    = (r_cnt == 2'd1);
  assign adh_page1 = sp_adloa;

  stack_seq_byteorder u_order (
    .i_op  (r_op),
    .i_idx (r_idx),
    .o_sel (w_sel)
  );

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    sp_clr   = 1'b0;
    sp_wa    = 1'b0;
    sp_dec   = 1'b0;
    sp_inc   = 1'b0;
    sp_sboa  = 1'b0;
    sp_adloa = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    byte_sel = SEL_SINGLE;
    case (r_state)
      // r_rdy holds sp_clr off while reset is asserted and for the release edge.
      ST_INIT: begin
        sp_clr = r_rdy;
        if (r_rdy) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_LOAD, OP_STORE:           w_next = ST_XFER;
            OP_PULL1, OP_PULL2, OP_PULL3: w_next = ST_PULL_PRE;
            default:                     w_next = ST_PUSH;
          endcase
        end
      end
      ST_PUSH: begin
        busy     = 1'b1;
        sp_adloa = 1'b1;
        mem_we   = 1'b1;
        sp_dec   = 1'b1;
        byte_sel = w_sel;
        done     = w_last;
        if (w_last) w_next = ST_IDLE;
      end
      ST_PULL_PRE: begin
        busy   = 1'b1;
        sp_inc = 1'b1;
        w_next = ST_PULL;
      end
      ST_PULL: begin
        busy     = 1'b1;
        sp_adloa = 1'b1;
        mem_re   = 1'b1;
        sp_inc   = ~w_last;
        byte_sel = w_sel;
        done     = w_last;
        if (w_last) w_next = ST_IDLE;
      end
      ST_XFER: begin
        busy    = 1'b1;
        done    = 1'b1;
        sp_wa   = (r_op == OP_LOAD);
        sp_sboa = (r_op == OP_STORE);
        w_next  = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= ST_INIT;
      r_op     <= OP_PUSH1;
      r_cnt    <= 2'd0;
      r_idx    <= 2'd0;
      r_shadow <= 8'h00;
      r_rdy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= 1'b1;
      case (r_state)
        ST_INIT: r_shadow <= SP_INIT;
        ST_IDLE: begin
          if (start) begin
            r_op  <= op_e'(op);
            r_cnt <= op_bytes(op_e'(op));
            r_idx <= 2'd0;
          end
        end
        ST_PUSH: begin
          r_shadow <= r_shadow - 8'd1;
          r_cnt    <= r_cnt - 2'd1;
          r_idx    <= r_idx + 2'd1;
        end
        ST_PULL_PRE: r_shadow <= r_shadow + 8'd1;
        ST_PULL: begin
          if (!w_last) r_shadow <= r_shadow + 8'd1;
          r_cnt <= r_cnt - 2'd1;
          r_idx <= r_idx + 2'd1;
        end
        ST_XFER: if (r_op == OP_LOAD) r_shadow <= sb_in;
        default: ;
      endcase
    end
  end

`ifdef STACK_SEQ_WRAP_CHK_EN
  logic r_err;
  logic w_wrap;

  assign w_wrap = ((r_state == ST_PUSH) && (r_shadow == 8'h00)) ||
                  (sp_inc && (r_shadow == 8'hFF));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)      r_err <= 1'b0;
    else if (w_wrap) r_err <= 1'b1;
  end

  assign stk_err = r_err;
`else
  assign stk_err = 1'b0;
`endif

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Sequences the 8-bit stack pointer register and the page-1 stack memory accesses for the 6502 core. The control unit issues one stack operation (single push/pull, JSR/RTS, BRK/IRQ, RTI, TXS, TSX) via a start/busy/done handshake. The block then drives the stack pointer's write, decrement, increment and bus-enable controls, along with the memory strobes and byte selects, cycle by cycle. Full-descending-stack semantics: push writes at SP then decrements; pull increments SP then reads.

## Interface
Parameters:
- SP_INIT, 8'hFA, value the stack pointer takes after reset; mirrored in the shadow copy.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only when busy=0.
- op  in  3  operation: 0 PUSH1, 1 PULL1, 2 PUSH2 (JSR), 3 PULL2 (RTS), 4 PUSH3 (BRK/IRQ), 5 PULL3 (RTI), 6 LOAD (TXS), 7 STORE (TSX).
- sb_in  in  8  SB bus value; copied into the shadow SP on LOAD.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse in the final active cycle.
- sp_clr, sp_wa, sp_dec, sp_inc, sp_sboa, sp_adloa  out  1 each  stack pointer controls.
- adh_page1  out  1  drive 8'h01 onto ADH; equals sp_adloa.
- mem_we, mem_re  out  1 each  memory write/read strobes.
- byte_sel  out  2  source/destination: 0 single (A/P chosen externally), 1 PCH, 2 PCL, 3 P.
- stk_err  out  1  sticky wrap error (see Configuration).

## Operation
- States: INIT, IDLE, PUSH, PULL_PRE, PULL, XFER. A 2-bit remaining-byte counter, a byte-index register and the shadow SP (8 bits) are held in flops.
- All outputs are decoded from the state and counter registers. No output depends combinationally on start/op.
- INIT: the state after reset release. Asserts sp_clr for exactly one cycle and sets shadow=SP_INIT, then goes to IDLE.
- IDLE: busy=0. When start=1, latch op, load the counter with n (1, 2 or 3), and move to PUSH, PULL_PRE or XFER.
- PUSH (n cycles): each cycle asserts sp_adloa, adh_page1, mem_we and sp_dec, and shadow decrements. byte_sel order: PUSH1 0; PUSH2 1,2; PUSH3 1,2,3.
- PULL_PRE (1 cycle): asserts sp_inc and shadow increments.
- PULL (n cycles): each cycle asserts sp_adloa, adh_page1 and mem_re. sp_inc is also asserted on every byte except the last. byte_sel order: PULL1 0; PULL2 2,1; PULL3 3,2,1.
- XFER (1 cycle): LOAD asserts sp_wa and sets shadow=sb_in; STORE asserts sp_sboa.
- done is asserted in the last cycle of PUSH, PULL or XFER. The next state is IDLE.
- Mutual exclusion: at most one of sp_wa/sp_dec/sp_inc, and at most one of mem_we/mem_re, is active per cycle.
- Shadow arithmetic is modulo 256: 8'h00 decrements to 8'hFF, and 8'hFF increments to 8'h00.
- start while busy=1 is ignored; no queuing.
- Reset mid-operation: clr_n low aborts immediately and asynchronously. All outputs go to 0, state goes to INIT, and the counter and shadow are cleared.

## Timing
- Reset values: every output is 0. sp_clr rises in the first cycle after clr_n deasserts.
- With start accepted at edge E, the first active cycle follows E.
- Latency to done: PUSHn is n cycles, PULLn is n+1 cycles, LOAD/STORE is 1 cycle.
- busy is high from the cycle after acceptance through the done cycle. It is low in the following cycle, and back-to-back start is accepted there.

## Configuration
- STACK_SEQ_WRAP_CHK_EN defined: stk_err is set when a push cycle sees shadow=8'h00, or when a PULL_PRE/PULL increment sees shadow=8'hFF. It stays set until reset. The operation still completes and wraps normally.
- Undefined: stk_err is tied to 0. The shadow SP is still maintained for LOAD/INIT consistency.

## Structure
- Shared package stack_seq_pkg holds:
  - the op enum (the 3-bit codes above);
  - the state enum;
  - the byte_sel constants SEL_SINGLE/SEL_PCH/SEL_PCL/SEL_P;
  - SP_PAGE=8'h01.
- One sub-module, stack_seq_byteorder: combinational mapping (op, byte index) -> byte_sel.
- The FSM, counter and shadow stay in the top module.

## Test plan
- Reset then idle: clr_n low for 3 cycles, then high. Every output is 0 during reset, sp_clr is 1 for exactly one cycle, and busy stays 0.
- PUSH2 at shadow 8'hFA: two cycles with mem_we/sp_dec and byte_sel 1 then 2. done is in cycle 2 and shadow ends at 8'hF8.
- PULL3 at shadow 8'hF7:
  - cycle 1 sp_inc only;
  - cycles 2–4 mem_re with byte_sel 3,2,1;
  - sp_inc in cycles 2–3 only;
  - done in cycle 4, shadow 8'hFA.
- LOAD with sb_in=8'h00, then PUSH1 with the macro defined: sp_wa for 1 cycle, the push wraps shadow to 8'hFF, and stk_err=1. With the macro undefined, stk_err stays 0.
- start asserted during busy, plus back-to-back: a second start mid-PUSH3 is ignored. A start in the first busy=0 cycle is accepted and busy rises in the next cycle.
- clr_n pulled low in the second cycle of PULL2: all outputs drop to 0 without waiting for a clock edge, and sp_clr pulses after release.
